// File: rtl/alu_seq.sv
// Sequential signed ALU: single-cycle SUB/NAND/LONES/OHDEC/ADD plus a WIDTH-cycle shift-add MUL.
// Define ALU_SEQ_SAT_EN to saturate SUB/ADD/MUL results on overflow instead of wrapping.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    input  logic [2:0]       i_oper,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flag
);

    localparam int MUL_CYC = WIDTH;
    localparam int CNTW    = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam int PW      = 2 * WIDTH;
    localparam int CW      = $clog2(PW + 1);
    localparam int IW      = $clog2(PW);
    localparam int MSB     = WIDTH - 1;

    localparam logic [2:0] OP_SUB   = 3'b000;
    localparam logic [2:0] OP_NAND  = 3'b001;
    localparam logic [2:0] OP_LONES = 3'b010;
    localparam logic [2:0] OP_OHDEC = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;

`ifdef ALU_SEQ_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_valid;
    logic [WIDTH-1:0]  r_result;
    logic [3:0]        r_flag;
    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_acc;
    logic              r_neg;
    logic [CNTW-1:0]   r_cnt;

    // Flag vector layout: [3] OVF, [2] POS, [1] NEG, [0] ERR.
    function automatic logic [3:0] make_flag(input logic [WIDTH-1:0] res,
                                             input logic err, input logic ovf);
        make_flag = {ovf, ~res[WIDTH-1] & (|res), res[WIDTH-1], err};
    endfunction

    logic [PW-1:0] w_cat;
    logic [CW-1:0] w_lones;
    logic          w_run;
    logic [CW-1:0] w_ones;
    logic [IW-1:0] w_idx;

    assign w_cat = {i_arg1, i_arg0};

    always_comb begin
        w_lones = '0;
        w_run   = 1'b1;
        w_ones  = '0;
        w_idx   = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            w_run   = w_run & w_cat[i];
            w_lones = w_lones + CW'(w_run);
            if (w_cat[i]) begin
                w_ones = w_ones + CW'(1);
                w_idx  = w_idx | IW'(i);
            end
        end
    end

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_err;
    logic             w_sc_ovf;

    assign w_diff = i_arg0 - i_arg1;
    assign w_sum  = i_arg0 + i_arg1;

    always_comb begin
        w_sc_res = '0;
        w_sc_err = 1'b0;
        w_sc_ovf = 1'b0;
        case (i_oper)
            OP_SUB: begin
                w_sc_res = w_diff;
                w_sc_ovf = (i_arg0[MSB] != i_arg1[MSB]) && (w_diff[MSB] != i_arg0[MSB]);
            end
            OP_NAND:  w_sc_res = ~(i_arg0 & i_arg1);
            OP_LONES: w_sc_res = WIDTH'(w_lones);
            OP_OHDEC: begin
                if (w_ones == CW'(1)) w_sc_res = WIDTH'(w_idx);
                else                  w_sc_err = 1'b1;
            end
            OP_ADD: begin
                w_sc_res = w_sum;
                w_sc_ovf = (i_arg0[MSB] == i_arg1[MSB]) && (w_sum[MSB] != i_arg0[MSB]);
            end
            default: w_sc_err = 1'b1;
        endcase
`ifdef ALU_SEQ_SAT_EN
        // On add/sub overflow the true result always carries the sign of A.
        if (w_sc_ovf) w_sc_res = i_arg0[MSB] ? SMIN : SMAX;
`endif
    end

    // Multiply magnitudes unsigned, then restore the sign on the final iteration.
    logic [WIDTH-1:0] w_abs0;
    logic [WIDTH-1:0] w_abs1;
    logic [PW-1:0]    w_mul_sum;
    logic [PW-1:0]    w_mul_prod;
    logic             w_mul_ovf;
    logic [WIDTH-1:0] w_mul_res;
    logic             w_mul_last;

    assign w_abs0     = i_arg0[MSB] ? -i_arg0 : i_arg0;
    assign w_abs1     = i_arg1[MSB] ? -i_arg1 : i_arg1;
    assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : {PW{1'b0}});
    assign w_mul_prod = r_neg ? -w_mul_sum : w_mul_sum;
    assign w_mul_ovf  = (|w_mul_prod[PW-1:MSB]) & ~(&w_mul_prod[PW-1:MSB]);
    assign w_mul_last = (r_cnt == CNTW'(MUL_CYC - 1));

    always_comb begin
        w_mul_res = w_mul_prod[WIDTH-1:0];
`ifdef ALU_SEQ_SAT_EN
        if (w_mul_ovf) w_mul_res = w_mul_prod[PW-1] ? SMIN : SMAX;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_flag   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (i_oper == OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, w_abs0};
                            r_mplier <= w_abs1;
                            r_acc    <= '0;
                            r_neg    <= i_arg0[MSB] ^ i_arg1[MSB];
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL_RUN;
                        end else begin
                            r_result <= w_sc_res;
                            r_flag   <= make_flag(w_sc_res, w_sc_err, w_sc_ovf);
                            r_valid  <= 1'b1;
                        end
                    end
                end
                S_MUL_RUN: begin
                    r_acc    <= w_mul_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNTW'(1);
                    if (w_mul_last) begin
                        r_result <= w_mul_res;
                        r_flag   <= make_flag(w_mul_res, 1'b0, w_mul_ovf);
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_flag   = r_flag;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=4): vector table for single-cycle ops, hand sequences for MUL and reset.
module tb_alu_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         valid = 1'b0;
    logic [2:0]   oper = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         o_busy;
    logic         o_valid;
    logic [W-1:0] o_result;
    logic [3:0]   o_flag;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_valid  (valid),
        .i_oper   (oper),
        .i_arg0   (a),
        .i_arg1   (b),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_flag   (o_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flag;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flag;
    } mul_t;

    vec_t vt[21];
    mul_t mt[5];

    // Packed view compared everywhere: {valid, busy, flag, result}.
    task automatic chk(input string name, input logic [W+5:0] got, input logic [W+5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got v/b/flag/res=%b expected %b", name, got, exp);
        end
        else begin
            $display("ok   %s: v/b/flag/res=%b", name, got);
        end
    endtask

    function automatic logic [W+5:0] outs();
        return {o_valid, o_busy, o_flag, o_result};
    endfunction

    initial begin
        logic saw;

        vt[0]  = '{3'b000, 4'd4,    4'd7,    4'b1101, 4'b0010};
`ifdef ALU_SEQ_SAT_EN
        vt[1]  = '{3'b000, 4'b0111, 4'b1000, 4'b0111, 4'b1100};
        vt[11] = '{3'b100, 4'b0111, 4'b0001, 4'b0111, 4'b1100};
        vt[12] = '{3'b100, 4'b1000, 4'b1111, 4'b1000, 4'b1010};
        vt[14] = '{3'b000, 4'b1000, 4'b0001, 4'b1000, 4'b1010};
`else
        vt[1]  = '{3'b000, 4'b0111, 4'b1000, 4'b1111, 4'b1010};
        vt[11] = '{3'b100, 4'b0111, 4'b0001, 4'b1000, 4'b1010};
        vt[12] = '{3'b100, 4'b1000, 4'b1111, 4'b0111, 4'b1100};
        vt[14] = '{3'b000, 4'b1000, 4'b0001, 4'b0111, 4'b1100};
`endif
        vt[2]  = '{3'b010, 4'b1100, 4'b1111, 4'b0110, 4'b0100};
        vt[3]  = '{3'b011, 4'b0000, 4'b0100, 4'b0110, 4'b0100};
        vt[4]  = '{3'b011, 4'b0101, 4'b0000, 4'b0000, 4'b0001};
        vt[5]  = '{3'b110, 4'b0011, 4'b0010, 4'b0000, 4'b0001};
        vt[6]  = '{3'b111, 4'b0011, 4'b0010, 4'b0000, 4'b0001};
        vt[7]  = '{3'b001, 4'b1111, 4'b0001, 4'b1110, 4'b0010};
        vt[8]  = '{3'b001, 4'b0000, 4'b0000, 4'b1111, 4'b0010};
        vt[9]  = '{3'b001, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
        vt[10] = '{3'b100, 4'd3,    4'd2,    4'b0101, 4'b0100};
        vt[13] = '{3'b000, 4'd0,    4'd0,    4'b0000, 4'b0000};
        vt[15] = '{3'b010, 4'b1111, 4'b1111, 4'b1000, 4'b0010};
        vt[16] = '{3'b010, 4'b1111, 4'b0111, 4'b0000, 4'b0000};
        vt[17] = '{3'b011, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vt[18] = '{3'b011, 4'b0000, 4'b1000, 4'b0111, 4'b0100};
        vt[19] = '{3'b011, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        vt[20] = '{3'b100, 4'b1111, 4'b0001, 4'b0000, 4'b0000};

        mt[0] = '{4'b0011, 4'b1110, 4'b1010, 4'b0010};
`ifdef ALU_SEQ_SAT_EN
        mt[1] = '{4'b0101, 4'b0101, 4'b0111, 4'b1100};
        mt[3] = '{4'b1000, 4'b1000, 4'b0111, 4'b1100};
`else
        mt[1] = '{4'b0101, 4'b0101, 4'b1001, 4'b1010};
        mt[3] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000};
`endif
        mt[2] = '{4'b1000, 4'b0001, 4'b1000, 4'b0010};
        mt[4] = '{4'b0000, 4'b1011, 4'b0000, 4'b0000};

        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", outs(), '0);
        @(negedge clk) rstn = 1'b1;

        // Back-to-back single-cycle ops, one result per edge.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            valid = 1'b1; oper = vt[i].op; a = vt[i].a; b = vt[i].b;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_op%b", i, vt[i].op), outs(), {2'b10, vt[i].flag, vt[i].res});
        end
        @(negedge clk) valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold", outs(), {2'b00, vt[20].flag, vt[20].res});

        // MUL: busy for W edges, an ADD driven meanwhile must be dropped.
        for (int m = 0; m < 5; m++) begin
            @(negedge clk);
            valid = 1'b1; oper = 3'b101; a = mt[m].a; b = mt[m].b;
            @(posedge clk); #1;
            chk($sformatf("mul%0d_accept", m), {o_valid, o_busy}, 2'b01);
            @(negedge clk);
            oper = 3'b100; a = ~mt[m].a; b = 4'b0110;
            for (int k = 1; k < W; k++) begin
                @(posedge clk); #1;
                chk($sformatf("mul%0d_busy%0d", m, k), {o_valid, o_busy}, 2'b01);
            end
            @(posedge clk); #1;
            chk($sformatf("mul%0d_done", m), outs(), {2'b10, mt[m].flag, mt[m].res});
            @(negedge clk) valid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("mul%0d_no_extra", m), outs(), {2'b00, mt[m].flag, mt[m].res});
        end

        // Reset two edges into a MUL aborts it without any completion.
        @(negedge clk);
        valid = 1'b1; oper = 3'b101; a = 4'b0011; b = 4'b0011;
        @(posedge clk); #1;
        @(negedge clk) valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mul_abort_busy", {o_valid, o_busy}, 2'b01);
        #1 rstn = 1'b0;
        #1 chk("async_reset", outs(), '0);
        @(negedge clk);
        @(negedge clk) rstn = 1'b1;
        saw = 1'b0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (o_valid) saw = 1'b1;
        end
        chk("no_valid_after_abort", {{(W+5){1'b0}}, saw}, '0);

        @(negedge clk);
        valid = 1'b1; oper = 3'b001; a = 4'b1111; b = 4'b0001;
        @(posedge clk); #1;
        chk("nand_after_reset", outs(), {2'b10, 4'b0010, 4'b1110});
        @(negedge clk) valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
